// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Memory geometry, request bundle and FSM states.
package mem_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin picker.
// Chooses the first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_c;

    // scan candidates in priority order starting at the pointer
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_c   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_c = w_sum[IW-1:0];
            if (!o_any && i_req[w_c]) begin
                o_any      = 1'b1;
                o_idx      = w_c;
                o_gnt[w_c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 256x64 data memory.
// One access in flight; read-before-write response per access.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
    input  logic [NUM_REQ-1:0]              req_we,
    output logic [NUM_REQ-1:0]              resp_valid,
    input  logic [NUM_REQ-1:0]              resp_ready,
    output logic [DATA_W-1:0]               resp_rdata,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_write_data,
    output logic                            mem_write_enable,
    input  logic [DATA_W-1:0]               mem_read_data,
    output logic                            busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e        r_state;
    arb_state_e        w_next;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_owner;
    mem_req_t          r_cur;
    logic [DATA_W-1:0] r_resp_q;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic               w_grant;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_grant = (r_state == IDLE) && w_any && !rst;

    // state register, grant capture and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_cur    <= '0;
            r_resp_q <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_cur <= '{addr:  req_addr[w_idx],
                           wdata: req_wdata[w_idx],
                           we:    req_we[w_idx]};
                r_owner <= w_idx;
                if (w_idx == IW'(NUM_REQ-1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_idx + IW'(1);
                end
            end
            if (r_state == WAIT) begin
                r_resp_q <= mem_read_data;
            end
        end
    end

    // next-state selection
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = RESP;
            RESP:    if (resp_ready[r_owner]) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // handshake and memory-port outputs
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (w_grant) begin
            req_ready = w_gnt;
        end
        if (r_state == RESP) begin
            resp_valid[r_owner] = 1'b1;
        end
    end

    assign resp_rdata       = r_resp_q;
    assign mem_addr         = r_cur.addr;
    assign mem_write_data   = r_cur.wdata;
    assign mem_write_enable = (r_state == ISSUE) && r_cur.we && !rst;
    assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter.
// Transaction-level reference with a shadow memory.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       d_rst;
    logic [N-1:0]               d_valid;
    logic [N-1:0][ADDR_W-1:0]   d_addr;
    logic [N-1:0][DATA_W-1:0]   d_wdata;
    logic [N-1:0]               d_we;
    logic [N-1:0]               d_rready;

    logic [N-1:0]       req_ready;
    logic [N-1:0]       resp_valid;
    logic [DATA_W-1:0]  resp_rdata;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_write_data;
    logic               mem_write_enable;
    logic [DATA_W-1:0]  mem_rd;
    logic               busy;

    mem_arbiter #(.NUM_REQ(N)) dut (
        .clk              (clk),
        .rst              (d_rst),
        .req_valid        (d_valid),
        .req_ready        (req_ready),
        .req_addr         (d_addr),
        .req_wdata        (d_wdata),
        .req_we           (d_we),
        .resp_valid       (resp_valid),
        .resp_ready       (d_rready),
        .resp_rdata       (resp_rdata),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_rd),
        .busy             (busy)
    );

    // memory macro: registered read of the pre-write word
    logic [DATA_W-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_addr] <= mem_write_data;
        mem_rd <= mem[mem_addr];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // reference: one transaction record plus shadow memory
    logic [DATA_W-1:0] ref_mem [256];
    int                cyc_n   = 0;
    bit                m_pend  = 0;
    int                m_g     = 0;
    int                m_owner = 0;
    int                m_ptr   = 0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [DATA_W-1:0] m_wd    = '0;
    logic [DATA_W-1:0] m_rd    = '0;
    bit                m_we    = 0;

    // one clock: check at negedge, retire granted requests after the edge
    task automatic step();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        logic [N-1:0] drop;
        bit           exp_we;
        int           w;
        drop = '0;
        @(negedge clk);
        if (d_rst) begin
            chk("rst_we", {63'd0, mem_write_enable}, 64'd0);
            chk("rst_rdy", {62'd0, req_ready}, 64'd0);
            m_pend = 0;
            m_ptr  = 0;
        end else begin
            exp_rdy = '0;
            if (!m_pend && |d_valid) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && d_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                exp_rdy[w] = 1'b1;
                m_pend  = 1;
                m_g     = cyc_n;
                m_owner = w;
                m_addr  = d_addr[w];
                m_wd    = d_wdata[w];
                m_we    = d_we[w];
                m_ptr   = (w + 1) % N;
                drop[w] = 1'b1;
            end
            chk("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
            chk("busy", {63'd0, busy}, {63'd0, m_pend && cyc_n > m_g});
            if (m_pend && cyc_n > m_g) chk("mem_addr", {56'd0, mem_addr}, {56'd0, m_addr});
            exp_we = m_pend && cyc_n == m_g + 1 && m_we;
            chk("mem_we", {63'd0, mem_write_enable}, {63'd0, exp_we});
            if (exp_we) chk("mem_wdata", mem_write_data, m_wd);
            if (m_pend && cyc_n == m_g + 1) begin
                m_rd = ref_mem[m_addr];
                if (m_we) ref_mem[m_addr] = m_wd;
            end
            exp_rv = '0;
            if (m_pend && cyc_n >= m_g + 3) exp_rv[m_owner] = 1'b1;
            chk("resp_valid", {62'd0, resp_valid}, {62'd0, exp_rv});
            if (|exp_rv) begin
                chk("resp_rdata", resp_rdata, m_rd);
                if (d_rready[m_owner]) m_pend = 0;
            end
        end
        cyc_n++;
        @(posedge clk);
        #1;
        d_valid = d_valid & ~drop;
    endtask

    task automatic access(input int r, input bit we,
                          input logic [7:0] a, input logic [63:0] wd);
        d_valid[r] = 1'b1;
        d_we[r]    = we;
        d_addr[r]  = a;
        d_wdata[r] = wd;
        d_rready   = '1;
        repeat (5) step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        d_rst = 1'b1; d_valid = '0; d_addr = '0;
        d_wdata = '0; d_we = '0; d_rready = '0;
        @(posedge clk); #1;
        repeat (2) step();
        d_rst = 1'b0;
        chk("rst_addr", {56'd0, mem_addr}, 64'd0);
        chk("rst_wdata", mem_write_data, 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // contention from reset: req0 then req1, then req0 again
        d_rready = '1;
        d_valid = 2'b11;
        d_addr[0] = 8'h01; d_addr[1] = 8'h02;
        repeat (9) step();
        d_valid = 2'b11;
        repeat (9) step();

        // write then read back at 0x10
        access(0, 1'b1, 8'h10, 64'hDEADBEEF_00000001);
        access(0, 1'b0, 8'h10, 64'h0);

        // backpressure on req1 while req0 waits
        d_valid[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h10;
        d_rready = 2'b01;
        step();
        d_valid[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h01;
        repeat (8) step();
        d_rready = 2'b11;
        repeat (6) step();

        // reset in the issue cycle of a write
        access(0, 1'b1, 8'h20, 64'h0000_0000_0000_0077);
        d_valid[0] = 1'b1; d_we[0] = 1'b1;
        d_addr[0] = 8'h20; d_wdata[0] = 64'h5555;
        step();
        d_rst = 1'b1;
        step();
        d_rst = 1'b0;
        repeat (4) step();
        access(1, 1'b0, 8'h20, 64'h0);

        // withdrawn request while req0 owns the memory
        d_valid[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h05;
        step();
        d_valid[1] = 1'b1;
        step();
        d_valid[1] = 1'b0;
        repeat (4) step();
        access(0, 1'b0, 8'h06, 64'h0);

        // top address and wrap neighbour
        access(1, 1'b1, 8'hFF, 64'h1234);
        access(0, 1'b0, 8'hFF, 64'h0);
        access(1, 1'b0, 8'h00, 64'h0);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            for (int r = 0; r < N; r++) begin
                d_valid[r] = ($urandom_range(0, 2) != 0);
                d_we[r]    = $urandom_range(0, 1) == 1;
                d_addr[r]  = ($urandom_range(0, 3) == 0) ?
                             8'($urandom_range(248, 255)) :
                             8'($urandom_range(0, 15));
                d_wdata[r] = {$urandom, $urandom};
                d_rready[r] = $urandom_range(0, 2) != 0;
            end
            d_rst = ($urandom_range(0, 199) == 0);
            step();
        end
        d_rst = 1'b0;
        d_valid = '0;
        d_rready = '1;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
